vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing for the minesweeper display path. Free-running horizontal and vertical pixel counters provide the `x`/`y` coordinates that the pixel-colour generator consumes. Sync and blanking strobes are delayed to line up with that generator's registered RGB. A per-frame tick and frame counter let game logic update the board during vertical blanking and blink the cursor.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch / sync in lines
- `CLK_DIV`, 2, system clocks per pixel; even, ≥2
- `PIPE_DLY`, 1, pixel delay applied to `hsync`/`vsync`/`blank_n`; 0..4
- `clk` in 1: system clock, 50 MHz
- `rst_n` in 1: reset, asynchronous, active-low
- `pix_en` out 1: one-`clk` pulse per pixel; counters advance on it
- `vga_clk` out 1: pixel clock to DAC, 50% duty, period `CLK_DIV` clk
- `x` out 10: horizontal count, 0..H_TOTAL-1 (H_TOTAL=800)
- `y` out 10: vertical count, 0..V_TOTAL-1 (V_TOTAL=525)
- `hsync` out 1: active-low horizontal sync, delayed `PIPE_DLY` pixels
- `vsync` out 1: active-low vertical sync, delayed `PIPE_DLY` pixels
- `blank_n` out 1: high in the visible region, delayed `PIPE_DLY` pixels
- `sync_n` out 1: tied 0 (no sync-on-green)
- `frame_tick` out 1: one-`clk` pulse at the start of vertical blanking
- `frame_cnt` out 8: frames completed, wraps 255→0

## Operation
- **Divider**
  - `div` counts 0..CLK_DIV-1 on every `clk`.
  - `pix_en` is registered, high exactly when `div==CLK_DIV-1`.
  - `vga_clk` is registered, high while `div>=CLK_DIV/2`.
- **Horizontal counter**: on `pix_en`, `x` increments; at H_TOTAL-1 it wraps to 0.
- **Vertical counter**:
  - `y` increments only on `pix_en` when `x==H_TOTAL-1`.
  - `y` wraps to 0 when `x==H_TOTAL-1` and `y==V_TOTAL-1`.
- **Raw strobes** (combinational from the counters):
  - hsync_raw=0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw=0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank_raw=1 iff x<H_ACTIVE and y<V_ACTIVE.
- **Delay line**
  - Raw strobes pass through a `PIPE_DLY`-stage shift register that advances only on `pix_en`.
  - `PIPE_DLY=0` means registered with zero pixel delay.
- **frame_tick / frame_cnt**
  - `frame_tick` is asserted for the single `clk` on which the counters become (0, V_ACTIVE).
  - `frame_cnt` increments on that same edge.
- **Reset values** (asynchronous on `rst_n` low; all delay stages included):
  - `div`=0, `x`=0, `y`=0, `pix_en`=0, `vga_clk`=0.
  - `hsync`=1, `vsync`=1, `blank_n`=0, `frame_tick`=0, `frame_cnt`=0.
- **Reset mid-frame**: the raster restarts at (0,0); no partial sync pulse may be emitted after release.
- `x`/`y` are always in range; out-of-range values are unreachable.

## Timing
- First `pix_en` occurs CLK_DIV clk edges after `rst_n` deasserts.
- `x`/`y` change on the edge following `pix_en`, and are stable for CLK_DIV clk.
- `hsync`/`vsync`/`blank_n` reflect counter value (x−PIPE_DLY) with wrap across lines and frames. They change on the same edge as `x`.
- Line period: 800 pixels. Frame period: 420000 pixels (8.4 ms × 2 at 50 MHz, CLK_DIV=2 → 16.8 ms).
- Simultaneous `x` wrap and `y` wrap: both go to 0 on the same edge, with no extra line.

## Structure
- **Package `vga_pkg`**:
  - `coord_t` (logic [9:0]).
  - Default 640x480 timing constants.
  - Derived `H_TOTAL`/`V_TOTAL` functions.
  - The board-cell geometry constants shared with the colour generator: left margin 80, cell pitch 61.
- **Sub-module `pixel_en_div`**: divider generating `pix_en` and `vga_clk`.
- Counters, strobe decode and delay line live in the top.

## Test plan
- **Reset release, CLK_DIV=2**: `pix_en` toggles every other clk; `vga_clk` period 40 ns, duty 50%; first `x` 0→1 at the 2nd edge.
- **Horizontal timing, PIPE_DLY=1**: `hsync` low exactly 96 pix_en.
  - Falls one pixel after `x` reaches 656.
  - Line-to-line falling-edge spacing is 800 pixels.
- **Vertical timing**:
  - `vsync` low for 1600 pixels, starting on line 490 (delayed 1 pixel).
  - `blank_n` high for 307200 pixels per frame.
- **Frame tick**: `frame_tick` pulses once per 420000 pix_en, at (x=0, y=480); `frame_cnt` advances 255→0 on the 256th frame.
- **Reset mid-line**: drop `rst_n` at x=700 (inside hsync). The bench must check:
  - `hsync`=1, `x`=`y`=0 immediately, without waiting for a clock edge.
  - After release, the next `hsync` fall is at x=657.
- **PIPE_DLY=0 vs 3**: `blank_n` rises at x=0 vs x=3 of each visible line, with the falling edge shifted equally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: coordinate type, strobe bundle, default
// 640x480@60 timing and the board geometry used by the colour generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    // Sync/blank strobes travel together through the alignment delay line.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
    } strobe_t;

    // Idle strobe value: syncs inactive, output blanked.
    localparam strobe_t STROBE_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

    // Default 640x480@60 Hz timing (pixels / lines).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_PIPE_DLY = 1;

    // Minesweeper board geometry, shared with the pixel-colour generator.
    localparam int unsigned BOARD_LEFT_MARGIN = 80;
    localparam int unsigned CELL_PITCH        = 61;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pixel_en_div.sv
// Divides the system clock down to the pixel rate: a one-clk pix_en strobe
// and a 50%-duty vga_clk for the DAC, both registered.
module pixel_en_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);
    localparam div_t DIV_HALF = div_t'(CLK_DIV / 2);

    div_t div_q;
    div_t div_d;
    logic pix_en_q;
    logic vga_clk_q;

    // Next divider phase, wrapping at CLK_DIV-1.
    always_comb begin
        div_d = div_q + div_t'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    // Outputs are decoded from the next phase so they track div_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_en_q  <= (div_d == DIV_LAST);
            vga_clk_q <= (div_d >= DIV_HALF);
        end
    end

    assign pix_en_o  = pix_en_q;
    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync/blank decode aligned to the
// colour generator's registered RGB, and a per-frame tick and counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       vga_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       sync_n,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic    pix_en_w;
    logic    vga_clk_w;
    coord_t  x_q;
    coord_t  x_d;
    coord_t  y_q;
    coord_t  y_d;
    strobe_t raw_d;
    logic    frame_start;
    logic    frame_tick_q;
    logic [7:0] frame_cnt_q;

    // Stage 0 holds the strobes for the current counter value; each further
    // stage adds one pixel of delay.
    strobe_t dly_q [0:PIPE_DLY];

    pixel_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_en_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en_o  (pix_en_w),
        .vga_clk_o (vga_clk_w)
    );

    // Next raster position: x wraps at end of line, y steps only on that wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en_w) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + coord_t'(1);
                end
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    // Raw strobes decoded from the position the counters are about to take,
    // so stage 0 lines up with x/y and PIPE_DLY=0 still gives a registered output.
    always_comb begin
        raw_d         = STROBE_IDLE;
        raw_d.hsync_n = !((x_d >= HS_START) && (x_d < HS_END));
        raw_d.vsync_n = !((y_d >= VS_START) && (y_d < VS_END));
        raw_d.blank_n = (x_d < H_VIS) && (y_d < V_VIS);
    end

    assign frame_start = pix_en_w && (x_d == '0) && (y_d == V_VIS);

    // Raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Strobe delay line; every stage resets idle so no partial sync pulse
    // can leak out after a mid-frame reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(PIPE_DLY); i++) begin
                dly_q[i] <= STROBE_IDLE;
            end
        end else if (pix_en_w) begin
            dly_q[0] <= raw_d;
            for (int i = 1; i <= int'(PIPE_DLY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Frame tick and counter, both updated on the edge entering vertical blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_tick_q <= frame_start;
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign pix_en     = pix_en_w;
    assign vga_clk    = vga_clk_w;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = dly_q[PIPE_DLY].hsync_n;
    assign vsync      = dly_q[PIPE_DLY].vsync_n;
    assign blank_n    = dly_q[PIPE_DLY].blank_n;
    assign sync_n     = 1'b0;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: full 640x480 instances with PIPE_DLY 1/0/3
// for line timing, plus a tiny-geometry instance for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Main instance, PIPE_DLY=1
    logic       m_pix_en, m_vga_clk, m_hsync, m_vsync, m_blank, m_sync_n, m_tick;
    logic [9:0] m_x, m_y;
    logic [7:0] m_cnt;
    // PIPE_DLY=0
    logic       z_pix_en, z_vga_clk, z_hsync, z_vsync, z_blank, z_sync_n, z_tick;
    logic [9:0] z_x, z_y;
    logic [7:0] z_cnt;
    // PIPE_DLY=3
    logic       t_pix_en, t_vga_clk, t_hsync, t_vsync, t_blank, t_sync_n, t_tick;
    logic [9:0] t_x, t_y;
    logic [7:0] t_cnt;
    // Small geometry: H 4+1+2+1=8, V 3+1+1+1=6, 48 pixels per frame
    logic       s_pix_en, s_vga_clk, s_hsync, s_vsync, s_blank, s_sync_n, s_tick;
    logic [9:0] s_x, s_y;
    logic [7:0] s_cnt;

    vga_timing_gen #(.PIPE_DLY(1)) u_main (
        .clk(clk), .rst_n(rst_n), .pix_en(m_pix_en), .vga_clk(m_vga_clk),
        .x(m_x), .y(m_y), .hsync(m_hsync), .vsync(m_vsync), .blank_n(m_blank),
        .sync_n(m_sync_n), .frame_tick(m_tick), .frame_cnt(m_cnt)
    );

    vga_timing_gen #(.PIPE_DLY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .pix_en(z_pix_en), .vga_clk(z_vga_clk),
        .x(z_x), .y(z_y), .hsync(z_hsync), .vsync(z_vsync), .blank_n(z_blank),
        .sync_n(z_sync_n), .frame_tick(z_tick), .frame_cnt(z_cnt)
    );

    vga_timing_gen #(.PIPE_DLY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .pix_en(t_pix_en), .vga_clk(t_vga_clk),
        .x(t_x), .y(t_y), .hsync(t_hsync), .vsync(t_vsync), .blank_n(t_blank),
        .sync_n(t_sync_n), .frame_tick(t_tick), .frame_cnt(t_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .PIPE_DLY(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .vga_clk(s_vga_clk),
        .x(s_x), .y(s_y), .hsync(s_hsync), .vsync(s_vsync), .blank_n(s_blank),
        .sync_n(s_sync_n), .frame_tick(s_tick), .frame_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int k;       // clk edge after reset release
        int pix_en;
        int vga_clk;
        int x;
        int y;
        int hs;      // main hsync
        int bl1;     // blank_n, PIPE_DLY=1
        int bl0;     // blank_n, PIPE_DLY=0
        int bl3;     // blank_n, PIPE_DLY=3
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge k after release.
    task automatic goto_edge(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int hs_low;
        int fall2;
        logic prev_hs;
        int hs_low_pre;
        int ticks;
        int bad_tick;
        int tick1;
        int tick2;
        int vs_low;
        int bl_hi;
        int vs_fall;
        logic prev_vs;

        // Hand-computed vectors (k, pix_en, vga_clk, x, y, hsync, blank d1/d0/d3)
        vecs.push_back('{1,    1, 1, 0,   0, 1, 0, 0, 0});
        vecs.push_back('{2,    0, 0, 1,   0, 1, 0, 1, 0});
        vecs.push_back('{3,    1, 1, 1,   0, 1, 0, 1, 0});
        vecs.push_back('{4,    0, 0, 2,   0, 1, 1, 1, 0});
        vecs.push_back('{5,    1, 1, 2,   0, 1, 1, 1, 0});
        vecs.push_back('{1280, 0, 0, 640, 0, 1, 1, 0, 1});
        vecs.push_back('{1282, 0, 0, 641, 0, 1, 0, 0, 1});
        vecs.push_back('{1312, 0, 0, 656, 0, 1, 0, 0, 0});
        vecs.push_back('{1314, 0, 0, 657, 0, 0, 0, 0, 0});
        vecs.push_back('{1504, 0, 0, 752, 0, 0, 0, 0, 0});
        vecs.push_back('{1506, 0, 0, 753, 0, 1, 0, 0, 0});
        vecs.push_back('{1600, 0, 0, 0,   1, 1, 0, 1, 0});
        vecs.push_back('{1602, 0, 0, 1,   1, 1, 1, 1, 0});
        vecs.push_back('{1604, 0, 0, 2,   1, 1, 1, 1, 0});
        vecs.push_back('{1606, 0, 0, 3,   1, 1, 1, 1, 1});
        vecs.push_back('{2878, 0, 0, 639, 1, 1, 1, 1, 1});
        vecs.push_back('{2880, 0, 0, 640, 1, 1, 1, 0, 1});
        vecs.push_back('{2882, 0, 0, 641, 1, 1, 0, 0, 1});
        vecs.push_back('{2884, 0, 0, 642, 1, 1, 0, 0, 1});
        vecs.push_back('{2886, 0, 0, 643, 1, 1, 0, 0, 0});
        vecs.push_back('{2912, 0, 0, 656, 1, 1, 0, 0, 0});
        vecs.push_back('{2914, 0, 0, 657, 1, 0, 0, 0, 0});

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst x", int'(m_x), 0);
        chk("rst y", int'(m_y), 0);
        chk("rst pix_en", int'(m_pix_en), 0);
        chk("rst vga_clk", int'(m_vga_clk), 0);
        chk("rst hsync", int'(m_hsync), 1);
        chk("rst vsync", int'(m_vsync), 1);
        chk("rst blank_n", int'(m_blank), 0);
        chk("rst sync_n", int'(m_sync_n), 0);
        chk("rst frame_tick", int'(m_tick), 0);
        chk("rst frame_cnt", int'(m_cnt), 0);
        chk("rst d3 blank_n", int'(t_blank), 0);
        chk("rst small frame_cnt", int'(s_cnt), 0);

        // Release away from the active edge
        rst_n  = 1'b1;
        edge_n = 0;

        foreach (vecs[i]) begin
            goto_edge(vecs[i].k);
            $display("vec k=%0d x=%0d y=%0d pix_en=%0d vga_clk=%0d hsync=%0d blank_n d1/d0/d3=%0d/%0d/%0d",
                     vecs[i].k, m_x, m_y, m_pix_en, m_vga_clk, m_hsync, m_blank, z_blank, t_blank);
            chk("vec pix_en", int'(m_pix_en), vecs[i].pix_en);
            chk("vec vga_clk", int'(m_vga_clk), vecs[i].vga_clk);
            chk("vec x", int'(m_x), vecs[i].x);
            chk("vec y", int'(m_y), vecs[i].y);
            chk("vec hsync", int'(m_hsync), vecs[i].hs);
            chk("vec blank_n d1", int'(m_blank), vecs[i].bl1);
            chk("vec blank_n d0", int'(z_blank), vecs[i].bl0);
            chk("vec blank_n d3", int'(t_blank), vecs[i].bl3);
        end

        // hsync width and line-to-line spacing on line 2
        hs_low  = 0;
        fall2   = -1;
        prev_hs = m_hsync;
        while (edge_n < 6200) begin
            goto_edge(edge_n + 1);
            if (edge_n >= 3200 && edge_n < 4800) begin
                if (!m_hsync) hs_low++;
                if (fall2 < 0 && prev_hs && !m_hsync) fall2 = edge_n;
            end
            prev_hs = m_hsync;
        end
        chk("hsync low clks line2", hs_low, 192);
        chk("hsync fall edge line2", fall2, 4514);
        $display("line2 hsync low=%0d clk fall=%0d", hs_low, fall2);

        // Reset inside the hsync pulse at x=700
        chk("pre-reset x", int'(m_x), 700);
        chk("pre-reset hsync", int'(m_hsync), 0);
        rst_n = 1'b0;
        #1;
        chk("async rst x", int'(m_x), 0);
        chk("async rst y", int'(m_y), 0);
        chk("async rst hsync", int'(m_hsync), 1);
        chk("async rst blank_n", int'(m_blank), 0);
        $display("mid-line reset x=%0d y=%0d hsync=%0d", m_x, m_y, m_hsync);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        hs_low_pre = 0;
        ticks      = 0;
        bad_tick   = 0;
        tick1      = -1;
        tick2      = -1;
        vs_low     = 0;
        bl_hi      = 0;
        vs_fall    = -1;
        prev_vs    = s_vsync;
        for (int k = 1; k <= 24600; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 40) begin
                chk("pix_en phase", int'(m_pix_en), k % 2);
                chk("vga_clk phase", int'(m_vga_clk), k % 2);
            end
            if (k < 1314 && !m_hsync) hs_low_pre++;
            if (k == 1312) begin
                chk("restart x 656", int'(m_x), 656);
                chk("restart hsync at 656", int'(m_hsync), 1);
            end
            if (k == 1313) chk("no partial hsync", hs_low_pre, 0);
            if (k == 1314) begin
                chk("restart x 657", int'(m_x), 657);
                chk("restart hsync fall", int'(m_hsync), 0);
            end
            if (s_tick) begin
                ticks++;
                if (s_x != 10'd0 || s_y != 10'd3) bad_tick++;
                if (tick1 < 0) tick1 = k;
                else if (tick2 < 0) tick2 = k;
            end
            if (k >= 96 && k <= 191) begin
                if (!s_vsync) vs_low++;
                if (s_blank) bl_hi++;
            end
            if (vs_fall < 0 && prev_vs && !s_vsync) vs_fall = k;
            prev_vs = s_vsync;
            if (k == 94) begin
                chk("small x before wrap", int'(s_x), 7);
                chk("small y before wrap", int'(s_y), 5);
            end
            if (k == 96) begin
                chk("small x after wrap", int'(s_x), 0);
                chk("small y after wrap", int'(s_y), 0);
            end
            if (k == 24526) chk("frame_cnt before 256th", int'(s_cnt), 255);
            if (k == 24528) begin
                chk("frame_tick 256th", int'(s_tick), 1);
                chk("frame_cnt wrap", int'(s_cnt), 0);
                $display("frame 256 tick=%0d frame_cnt=%0d", s_tick, s_cnt);
            end
        end
        chk("frame_tick count", ticks, 256);
        chk("frame_tick position", bad_tick, 0);
        chk("first frame_tick edge", tick1, 48);
        chk("second frame_tick edge", tick2, 144);
        chk("vsync low clks per frame", vs_low, 16);
        chk("blank_n high clks per frame", bl_hi, 24);
        chk("vsync first fall edge", vs_fall, 66);
        chk("main frame_cnt mid-frame", int'(m_cnt), 0);
        $display("frames ticks=%0d vsync_low=%0d blank_hi=%0d", ticks, vs_low, bl_hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
